pipe_reg_m_skid: RTL and testbench

- Parametrised EX→MEM pipeline register; successor to the fixed 32-bit E/M latch.
- Carries IR, PC+4, ALU result, store data and destination register from EX to MEM.
- Adds valid/ready handshake, optional one-entry skid buffer so upstream ready is a registered signal, synchronous flush, and a saturating flush counter for performance monitoring.

---
 rtl/pipe_reg_m_skid.sv | 178 +++++++++++++++++
 tb/tb_pipe_reg_m_skid.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_m_skid.sv
// EX->MEM pipeline register with a valid/ready handshake, an optional one-entry
// skid buffer that keeps o_ready_e registered, a synchronous flush that turns
// the stage into a bubble, and a saturating count of entries killed by flush.
module pipe_reg_m_skid #(
  parameter int                DATA_W   = 32,
  parameter int                REG_AW   = 5,
  parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(32'h0000_3000),
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid_e,
  output logic              o_ready_e,
  input  logic [DATA_W-1:0] i_ir_e,
  input  logic [DATA_W-1:0] i_pc4_e,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic [DATA_W-1:0] i_alu_b,
  input  logic [REG_AW-1:0] i_a3_e,
  input  logic              i_flush,
  input  logic              i_ready_m,
  output logic              o_valid_m,
  output logic [DATA_W-1:0] o_ir_m,
  output logic [DATA_W-1:0] o_pc4_m,
  output logic [DATA_W-1:0] o_ao_m,
  output logic [DATA_W-1:0] o_v2_m,
  output logic [REG_AW-1:0] o_a3_m,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] ao;
    logic [DATA_W-1:0] v2;
    logic [REG_AW-1:0] a3;
  } entry_t;

  // Occupancy: EMPTY = nothing held, ONE = main only, FULL = main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  entry_t           r_main;
  entry_t           r_skid;
  entry_t           w_in_entry;
  logic             r_ready_e;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W:0]   w_cnt_sum;
  logic             w_ready_e;
  logic             w_in;
  logic             w_out;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;
  logic [1:0]       w_disc;

  assign w_in_entry = {i_ir_e, i_pc4_e, i_alu_out, i_alu_b, i_a3_e};

  // Without a skid slot the stage can only accept while MEM is draining it,
  // so ready has to follow i_ready_m combinationally.
  generate
    if (SKID != 0) begin : g_skid
      assign w_ready_e = r_ready_e;
    end else begin : g_noskid
      assign w_ready_e = i_ready_m | (r_state == ST_EMPTY);
    end
  endgenerate

  assign w_in  = i_valid_e & w_ready_e;
  assign w_out = (r_state != ST_EMPTY) & i_ready_m;

  // Next occupancy, datapath load enables and the number of entries a flush kills.
  always_comb begin
    w_state_next     = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_disc           = 2'd0;
    if (i_flush) begin
      // An entry leaving to MEM this cycle was consumed, not discarded.
      w_state_next = ST_EMPTY;
      case (r_state)
        ST_ONE:  w_disc = i_ready_m ? 2'd0 : 2'd1;
        ST_FULL: w_disc = i_ready_m ? 2'd1 : 2'd2;
        default: w_disc = 2'd0;
      endcase
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in) begin
            w_state_next = ST_ONE;
            w_load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in && w_out) begin
            w_load_main = 1'b1;
          end else if (w_out) begin
            w_state_next = ST_EMPTY;
          end else if (w_in) begin
            // Only reachable with a skid slot: main is stalled, park the input.
            w_state_next = ST_FULL;
            w_load_skid  = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_out) begin
            w_state_next     = ST_ONE;
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state and the registered upstream ready (low only when FULL).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_EMPTY;
      r_ready_e <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_ready_e <= (w_state_next != ST_FULL);
    end
  end

  // Main register; a flush leaves a bubble with no writeback target.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main     <= '0;
      r_main.pc4 <= PC_RESET;
    end else if (i_flush) begin
      r_main.ir <= '0;
      r_main.a3 <= '0;
    end else if (w_load_main) begin
      r_main <= w_main_from_skid ? r_skid : w_in_entry;
    end
  end

  // Skid register holds the one entry accepted while main was stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_skid <= '0;
    end else if (w_load_skid) begin
      r_skid <= w_in_entry;
    end
  end

  assign w_cnt_sum = {1'b0, r_flush_cnt} + (CNT_W + 1)'(w_disc);

  // Saturating count of valid entries thrown away by flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flush_cnt <= '0;
    end else if (w_cnt_sum[CNT_W]) begin
      r_flush_cnt <= '1;
    end else begin
      r_flush_cnt <= w_cnt_sum[CNT_W-1:0];
    end
  end

  assign o_ready_e   = w_ready_e;
  assign o_valid_m   = (r_state != ST_EMPTY);
  assign o_ir_m      = r_main.ir;
  assign o_pc4_m     = r_main.pc4;
  assign o_ao_m      = r_main.ao;
  assign o_v2_m      = r_main.v2;
  assign o_a3_m      = r_main.a3;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_reg_m_skid.sv
// Scoreboard bench: the negedge monitors hold a queue per instance of what each
// DUT should be holding, compare outputs against it and track the flush count.
module tb_pipe_reg_m_skid;
  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance with skid buffer
  logic          valid_e, flush, ready_m;
  logic [DW-1:0] ir_e, pc4_e, ao_e, v2_e;
  logic [AW-1:0] a3_e;
  wire           ready_e, valid_m;
  wire  [DW-1:0] ir_m, pc4_m, ao_m, v2_m;
  wire  [AW-1:0] a3_m;
  wire  [CW-1:0] flush_cnt;

  // Instance without skid buffer
  logic          valid_e0, flush0, ready_m0;
  logic [DW-1:0] ir_e0, pc4_e0, ao_e0, v2_e0;
  logic [AW-1:0] a3_e0;
  wire           ready_e0, valid_m0;
  wire  [DW-1:0] ir_m0, pc4_m0, ao_m0, v2_m0;
  wire  [AW-1:0] a3_m0;
  wire  [CW-1:0] flush_cnt0;

  pipe_reg_m_skid #(.DATA_W(DW), .REG_AW(AW), .SKID(1), .CNT_W(CW)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_e(valid_e), .o_ready_e(ready_e),
    .i_ir_e(ir_e), .i_pc4_e(pc4_e), .i_alu_out(ao_e), .i_alu_b(v2_e), .i_a3_e(a3_e),
    .i_flush(flush), .i_ready_m(ready_m), .o_valid_m(valid_m),
    .o_ir_m(ir_m), .o_pc4_m(pc4_m), .o_ao_m(ao_m), .o_v2_m(v2_m), .o_a3_m(a3_m),
    .o_flush_cnt(flush_cnt)
  );

  pipe_reg_m_skid #(.DATA_W(DW), .REG_AW(AW), .SKID(0), .CNT_W(CW)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_e(valid_e0), .o_ready_e(ready_e0),
    .i_ir_e(ir_e0), .i_pc4_e(pc4_e0), .i_alu_out(ao_e0), .i_alu_b(v2_e0), .i_a3_e(a3_e0),
    .i_flush(flush0), .i_ready_m(ready_m0), .o_valid_m(valid_m0),
    .o_ir_m(ir_m0), .o_pc4_m(pc4_m0), .o_ao_m(ao_m0), .o_v2_m(v2_m0), .o_a3_m(a3_m0),
    .o_flush_cnt(flush_cnt0)
  );

  typedef struct {
    logic [DW-1:0] ir;
    logic [DW-1:0] pc4;
    logic [DW-1:0] ao;
    logic [DW-1:0] v2;
    logic [AW-1:0] a3;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];
  int   errors  = 0;
  int   checks  = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Field pattern derived from the instruction word: pc4 = 0x3004 + 4*ir,
  // ao = ir ^ 0xA5A50000, v2 = ~ir, a3 = ir[4:0] | 0x10 (never zero).
  task automatic drive1(input logic v, input logic [31:0] ir, input logic fl, input logic rm);
    logic [31:0] t;
    t       = ir;
    valid_e = v;
    ir_e    = t;
    pc4_e   = 32'h0000_3004 + (t << 2);
    ao_e    = t ^ 32'hA5A5_0000;
    v2_e    = ~t;
    a3_e    = t[4:0] | 5'h10;
    flush   = fl;
    ready_m = rm;
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] ir, input logic rm);
    logic [31:0] t;
    t        = ir;
    valid_e0 = v;
    ir_e0    = t;
    pc4_e0   = 32'h0000_3004 + (t << 2);
    ao_e0    = t ^ 32'hA5A5_0000;
    v2_e0    = ~t;
    a3_e0    = t[4:0] | 5'h10;
    ready_m0 = rm;
  endtask

  // Monitor for the skid instance
  always @(negedge clk) begin : mon1
    int   n;
    logic exp_rdy;
    int   sum;
    if (rst_n) begin
      n       = q1.size();
      exp_rdy = (n < 2);
      chk("ready_e", ready_e, exp_rdy);
      chk("valid_m", valid_m, n > 0);
      chk("flush_cnt", flush_cnt, exp_cnt);
      if (n > 0) begin
        chk("ir_m",  ir_m,  q1[0].ir);
        chk("pc4_m", pc4_m, q1[0].pc4);
        chk("ao_m",  ao_m,  q1[0].ao);
        chk("v2_m",  v2_m,  q1[0].v2);
        chk("a3_m",  a3_m,  q1[0].a3);
        $display("mon1 t=%0t ir_m=%0h ready_m=%0b flush=%0b", $time, ir_m, ready_m, flush);
        if (ready_m) void'(q1.pop_front());
      end
      if (flush) begin
        sum     = exp_cnt + q1.size();
        exp_cnt = (sum > CNT_MAX) ? CNT_MAX : sum;
        q1.delete();
      end else if (valid_e && exp_rdy) begin
        q1.push_back('{ir: ir_e, pc4: pc4_e, ao: ao_e, v2: v2_e, a3: a3_e});
      end
    end
  end

  // Monitor for the no-skid instance
  always @(negedge clk) begin : mon0
    int   n;
    logic exp_rdy;
    if (rst_n) begin
      n       = q0.size();
      exp_rdy = ready_m0 || (n == 0);
      chk("ready_e0", ready_e0, exp_rdy);
      chk("valid_m0", valid_m0, n > 0);
      chk("flush_cnt0", flush_cnt0, 0);
      if (n > 0) begin
        chk("ir_m0", ir_m0, q0[0].ir);
        chk("a3_m0", a3_m0, q0[0].a3);
        $display("mon0 t=%0t ir_m=%0h ready_m=%0b", $time, ir_m0, ready_m0);
        if (ready_m0) void'(q0.pop_front());
      end
      if (valid_e0 && exp_rdy) begin
        q0.push_back('{ir: ir_e0, pc4: pc4_e0, ao: ao_e0, v2: v2_e0, a3: a3_e0});
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    flush0 = 1'b0;
    set0(1'b0, 32'h0, 1'b1);
    drive1(1'b0, 32'h0, 1'b0, 1'b1);
    drive1(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst valid_m", valid_m, 1'b0);
    chk("rst pc4_m", pc4_m, 32'h0000_3000);
    chk("rst ir_m", ir_m, 32'h0);
    chk("rst a3_m", a3_m, 5'h0);
    chk("rst flush_cnt", flush_cnt, 0);
    chk("rst ready_e", ready_e, 1'b1);
    rst_n = 1'b1;

    // Streaming with MEM always ready: one entry per cycle
    drive1(1'b1, 32'h1, 1'b0, 1'b1); chk("stream ir 1", ir_m, 32'h1);
    drive1(1'b1, 32'h2, 1'b0, 1'b1); chk("stream ir 2", ir_m, 32'h2);
    drive1(1'b1, 32'h3, 1'b0, 1'b1); chk("stream ir 3", ir_m, 32'h3);
    drive1(1'b0, 32'h0, 1'b0, 1'b1);
    drive1(1'b0, 32'h0, 1'b0, 1'b1);

    // Stall fills the skid, then drains in order
    drive1(1'b1, 32'hA, 1'b0, 1'b0); chk("stall ir A", ir_m, 32'hA);
    drive1(1'b1, 32'hB, 1'b0, 1'b0);
    chk("full ready_e", ready_e, 1'b0);
    chk("full ir A", ir_m, 32'hA);
    drive1(1'b0, 32'h0, 1'b0, 1'b0); chk("hold ir A", ir_m, 32'hA);
    drive1(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain ir B", ir_m, 32'hB);
    chk("drain ready_e", ready_e, 1'b1);
    drive1(1'b0, 32'h0, 1'b0, 1'b1); chk("drained valid", valid_m, 1'b0);

    // Flush while FULL with a new input presented: both entries counted, input dropped
    drive1(1'b1, 32'h10, 1'b0, 1'b0);
    drive1(1'b1, 32'h11, 1'b0, 1'b0);
    drive1(1'b1, 32'hC, 1'b1, 1'b0);
    chk("flush valid_m", valid_m, 1'b0);
    chk("flush ir_m", ir_m, 32'h0);
    chk("flush a3_m", a3_m, 5'h0);
    chk("flush pc4 hold", pc4_m, 32'h0000_3044);
    chk("flush ao hold", ao_m, 32'hA5A5_0010);
    chk("flush cnt 2", flush_cnt, 2);
    chk("flush ready_e", ready_e, 1'b1);
    drive1(1'b0, 32'h0, 1'b0, 1'b1);
    drive1(1'b0, 32'h0, 1'b0, 1'b1);

    // Flush while FULL and MEM consuming: only the skid entry is discarded
    drive1(1'b1, 32'h12, 1'b0, 1'b0);
    drive1(1'b1, 32'h13, 1'b0, 1'b0);
    drive1(1'b0, 32'h0, 1'b1, 1'b1);
    chk("flush+out cnt 3", flush_cnt, 3);

    // Climb toward saturation: five double flushes, then one single
    for (int k = 0; k < 5; k++) begin
      drive1(1'b1, 32'h20 + k, 1'b0, 1'b0);
      drive1(1'b1, 32'h28 + k, 1'b0, 1'b0);
      drive1(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("cnt 13", flush_cnt, 13);
    drive1(1'b1, 32'h40, 1'b0, 1'b0);
    drive1(1'b0, 32'h0, 1'b1, 1'b0);
    chk("cnt 14", flush_cnt, 14);
    for (int k = 0; k < 2; k++) begin
      drive1(1'b1, 32'h50 + k, 1'b0, 1'b0);
      drive1(1'b1, 32'h58 + k, 1'b0, 1'b0);
      drive1(1'b0, 32'h0, 1'b1, 1'b0);
      chk("cnt saturated", flush_cnt, CNT_MAX);
    end

    // Asynchronous reset mid-stream
    drive1(1'b1, 32'h60, 1'b0, 1'b0);
    chk("pre-reset valid", valid_m, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid_m", valid_m, 1'b0);
    chk("arst pc4_m", pc4_m, 32'h0000_3000);
    chk("arst ir_m", ir_m, 32'h0);
    chk("arst flush_cnt", flush_cnt, 0);
    q1.delete();
    q0.delete();
    exp_cnt = 0;
    drive1(1'b0, 32'h0, 1'b0, 1'b1);
    rst_n = 1'b1;
    drive1(1'b0, 32'h0, 1'b0, 1'b1);

    // No-skid instance: combinational ready follows MEM while holding an entry
    set0(1'b1, 32'h30, 1'b0);
    @(posedge clk); #1;
    chk("ns ir 30", ir_m0, 32'h30);
    set0(1'b1, 32'h31, 1'b0);
    #1 chk("ns ready low", ready_e0, 1'b0);
    @(posedge clk); #1;
    chk("ns hold 30", ir_m0, 32'h30);
    set0(1'b1, 32'h32, 1'b1);
    #1 chk("ns ready high", ready_e0, 1'b1);
    @(posedge clk); #1;
    chk("ns ir 32", ir_m0, 32'h32);
    set0(1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("ns drained", valid_m0, 1'b0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
